// File: rtl/branch_fetch_sequencer.sv
// Multicycle fetch/issue/resolve sequencer that owns the program counter.
// Optional macro PC_REL_BRANCH_EN makes BLT/BGT/BEQ targets PC-relative (JUMP stays absolute).
module branch_fetch_sequencer #(
  parameter int OPSIZE  = 4,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               zero,
  input  logic               sign,
  output logic [ADDR_W-1:0]  pc,
  output logic               branch_taken,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_RESOLVE,
    S_HALT
  } state_t;

  localparam logic [OPSIZE-1:0] OP_BLT  = OPSIZE'('h4);
  localparam logic [OPSIZE-1:0] OP_BGT  = OPSIZE'('h5);
  localparam logic [OPSIZE-1:0] OP_BEQ  = OPSIZE'('h6);
  localparam logic [OPSIZE-1:0] OP_JUMP = OPSIZE'('hC);
  localparam logic [OPSIZE-1:0] OP_HALT = OPSIZE'('hF);

  state_t            state, state_nxt;
  logic              zero_q, sign_q;
  logic [OPSIZE-1:0] opcode;
  logic [ADDR_W-1:0] target_field, cond_target, branch_target;
  logic              taken, is_halt;

  assign opcode       = instr[INSTR_W-1 -: OPSIZE];
  assign target_field = instr[ADDR_W-1:0];
  assign is_halt      = (opcode == OP_HALT);
  assign imem_addr    = pc;

`ifdef PC_REL_BRANCH_EN
  // The offset field is already ADDR_W wide, so its sign extension is the field itself.
  assign cond_target = pc + target_field;
`else
  assign cond_target = target_field;
`endif

  assign branch_target = (opcode == OP_JUMP) ? target_field : cond_target;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BLT:  taken = sign_q & ~zero_q;
      OP_BGT:  taken = ~sign_q & ~zero_q;
      OP_BEQ:  taken = zero_q;
      OP_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      instr  <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) begin
        instr <= imem_data;
      end
      if (state == S_WAIT && exec_done) begin
        zero_q <= zero;
        sign_q <= sign;
      end
      if (state == S_RESOLVE && !is_halt) begin
        pc <= taken ? branch_target : pc + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    branch_taken = 1'b0;
    halted       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done) state_nxt = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          branch_taken = taken;
          state_nxt    = S_IDLE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Self-checking bench for branch_fetch_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_branch_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_ack, instr_valid, exec_done, zero, sign;
  logic        branch_taken, halted;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_data, instr;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit check_en     = 1'b0;

  localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_WAIT = 3, M_RESOLVE = 4, M_HALT = 5;
  int          m_phase;
  int          m_pc;
  logic [15:0] m_instr;
  bit          m_z, m_s;

`ifdef PC_REL_BRANCH_EN
  localparam logic [7:0] T2_TARGET = 8'h50;
  localparam logic [7:0] T6_PC     = 8'h03;
`else
  localparam logic [7:0] T2_TARGET = 8'h40;
  localparam logic [7:0] T6_PC     = 8'hFE;
`endif

  branch_fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .zero(zero), .sign(sign),
    .pc(pc), .branch_taken(branch_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic bit ref_taken(logic [15:0] ins, bit z, bit s);
    case (ins[15:12])
      4'h4:    return s && !z;
      4'h5:    return !s && !z;
      4'h6:    return z;
      4'hC:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_target(logic [15:0] ins, int cur_pc);
    int field;
    field = int'(ins[7:0]);
    if (ins[15:12] == 4'hC) return field;
`ifdef PC_REL_BRANCH_EN
    if (field >= 128) field = field - 256;
    return ((cur_pc + field) % 256 + 256) % 256;
`else
    return field;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction pass as a sequence of phases, fed by the same inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE;
      m_pc    = 0;
      m_instr = 16'h0;
      m_z     = 1'b0;
      m_s     = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE:  if (run) m_phase = M_FETCH;
        M_FETCH: if (imem_ack) begin m_instr = imem_data; m_phase = M_ISSUE; end
        M_ISSUE: m_phase = M_WAIT;
        M_WAIT:  if (exec_done) begin m_z = zero; m_s = sign; m_phase = M_RESOLVE; end
        M_RESOLVE: begin
          if (m_instr[15:12] == 4'hF) begin
            m_phase = M_HALT;
          end else begin
            m_pc    = ref_taken(m_instr, m_z, m_s) ? ref_target(m_instr, m_pc) : (m_pc + 1) % 256;
            m_phase = M_IDLE;
          end
        end
        default: m_phase = M_HALT;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_imem_req", imem_req, m_phase == M_FETCH);
      checkOutput("m_imem_addr", imem_addr, m_pc);
      checkOutput("m_instr", instr, m_instr);
      checkOutput("m_instr_valid", instr_valid, m_phase == M_ISSUE);
      checkOutput("m_pc", pc, m_pc);
      checkOutput("m_branch_taken", branch_taken,
                  m_phase == M_RESOLVE && ref_taken(m_instr, m_z, m_s));
      checkOutput("m_halted", halted, m_phase == M_HALT);
    end
  end

  // Runs one full pass from IDLE; ends at the negedge after RESOLVE (back in IDLE).
  task automatic applyStimulus(input logic [15:0] data, input bit z, input bit s, input int ack_delay,
                               input logic [7:0] exp_addr, input bit exp_taken, input logic [7:0] exp_pc);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (ack_delay) begin
      checkOutput("fetch_req", imem_req, 1'b1);
      checkOutput("fetch_addr", imem_addr, exp_addr);
      @(negedge clk);
    end
    checkOutput("fetch_addr", imem_addr, exp_addr);
    imem_ack  = 1'b1;
    imem_data = data;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    checkOutput("issue_valid", instr_valid, 1'b1);
    checkOutput("issue_instr", instr, data);
    @(negedge clk);
    checkOutput("wait_valid", instr_valid, 1'b0);
    exec_done = 1'b1;
    zero      = z;
    sign      = s;
    @(negedge clk);
    exec_done = 1'b0;
    checkOutput("resolve_taken", branch_taken, exp_taken);
    @(negedge clk);
    checkOutput("next_pc", pc, exp_pc);
    checkOutput("idle_taken", branch_taken, 1'b0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ops [3];
    bit         tbl [12];
    logic [7:0] cur;
    logic [1:0] cb;
    logic [3:0] op;
    bit         t;

    ops = '{4'h4, 4'h5, 4'h6};
    tbl = '{0, 1, 0, 0,  1, 0, 0, 0,  0, 0, 1, 1};
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
    exec_done = 1'b0; zero = 1'b0; sign = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_req", imem_req, 1'b0);
    checkOutput("reset_pc", pc, 8'h00);
    checkOutput("reset_instr", instr, 16'h0);
    checkOutput("reset_halted", halted, 1'b0);

    // T1: slow acknowledge, non-branch advances PC by one
    applyStimulus(16'h1234, 1'b0, 1'b0, 3, 8'h00, 1'b0, 8'h01);
    cur = 8'h01;

    // T2: conditional branch truth table at PC 0x10, target field 0x40
    for (int o = 0; o < 3; o++) begin
      for (int c = 0; c < 4; c++) begin
        cb = c[1:0];
        t  = tbl[o*4 + c];
        applyStimulus(16'hC010, 1'b0, 1'b0, 0, cur, 1'b1, 8'h10);
        applyStimulus({ops[o], 4'h0, 8'h40}, cb[1], cb[0], $urandom_range(0, 2), 8'h10, t,
                      t ? T2_TARGET : 8'h11);
        cur = t ? T2_TARGET : 8'h11;
      end
    end

    // T3: wrap-around at the top of the address space
    applyStimulus(16'hC0FF, 1'b0, 1'b0, 0, cur, 1'b1, 8'hFF);
    applyStimulus(16'hC000, 1'b0, 1'b0, 1, 8'hFF, 1'b1, 8'h00);
    applyStimulus(16'hC0FF, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'hFF);
    applyStimulus(16'h0000, 1'b1, 1'b1, 0, 8'hFF, 1'b0, 8'h00);
    applyStimulus(16'hC0FF, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'hFF);
    applyStimulus(16'h6012, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 8'h00);

    // T4: reset during an outstanding request, acknowledge arrives late
    applyStimulus(16'hC033, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'h33);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checkOutput("t4_req_before", imem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_data = 16'hC055;
    checkOutput("t4_req_after_rst", imem_req, 1'b0);
    checkOutput("t4_pc_after_rst", pc, 8'h00);
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("t4_req_late_ack", imem_req, 1'b0);
    checkOutput("t4_instr_late_ack", instr, 16'h0);
    checkOutput("t4_valid_late_ack", instr_valid, 1'b0);
    @(negedge clk);
    checkOutput("t4_req_idle", imem_req, 1'b0);

    // T5: HALT freezes everything until reset
    applyStimulus(16'hC022, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'h22);
    applyStimulus(16'hF000, 1'b0, 1'b0, 0, 8'h22, 1'b0, 8'h22);
    checkOutput("t5_halted", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); imem_ack = 1'($urandom); exec_done = 1'($urandom);
      imem_data = 16'($urandom);
      @(negedge clk);
      checkOutput("t5_req", imem_req, 1'b0);
      checkOutput("t5_pc", pc, 8'h22);
      checkOutput("t5_halted_hold", halted, 1'b1);
    end
    run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    pulseReset();
    checkOutput("t5_unhalt", halted, 1'b0);

    // T6: BEQ with offset field 0xFE at PC 0x05
    applyStimulus(16'hC005, 1'b0, 1'b0, 0, 8'h00, 1'b1, 8'h05);
    applyStimulus(16'h60FE, 1'b1, 1'b0, 1, 8'h05, 1'b1, T6_PC);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      run       = 1'($urandom);
      imem_ack  = 1'($urandom);
      exec_done = 1'($urandom);
      zero      = 1'($urandom);
      sign      = 1'($urandom);
      case ($urandom_range(0, 7))
        0: op = 4'h4;
        1: op = 4'h5;
        2: op = 4'h6;
        3: op = 4'hC;
        4: op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
        default: op = 4'($urandom);
      endcase
      imem_data = {op, 12'($urandom)};
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
